// File: rtl/trng_key_fifo.sv
// Health-checked key buffer behind the TRNG core: captures core words with a
// one-cycle ack, runs a repetition-count test, and queues passing words.
module trng_key_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RCT_CUTOFF = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     key_ready_i,
    input  logic [WIDTH-1:0]         key_i,
    output logic                     ack_read_o,
    input  logic                     rd_req_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic [$clog2(DEPTH):0]   threshold_i,
    output logic                     rct_fail_o,
    output logic                     intr_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = $clog2(RCT_CUTOFF) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACK_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              rct_fail_q, rct_fail_d;
    logic              intr_q, intr_d;
    logic [WIDTH-1:0]  last_word_q, last_word_d;
    logic              last_valid_q, last_valid_d;
    logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              full, empty, capture, match, fail_hit, push, pop;
    logic [RW-1:0]     rep_inc;

    // Full/empty come from the registered level, so a same-cycle pop never unblocks a capture.
    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        capture  = (state_q == ST_IDLE) && enable_i && key_ready_i && !full
                   && !rct_fail_q && !clear_i;
        match    = last_valid_q && (key_i == last_word_q);
        rep_inc  = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + RW'(1);
        fail_hit = capture && match && (rep_inc >= RW'(RCT_CUTOFF));
        push     = capture && !fail_hit;
        pop      = rd_req_i && !empty && !clear_i;
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        rct_fail_d   = rct_fail_q;
        last_word_d  = last_word_q;
        last_valid_d = last_valid_q;
        rep_cnt_d    = rep_cnt_q;
        intr_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_ACK_WAIT;
                    ack_d   = 1'b1;
                end
            end
            ST_ACK_WAIT: begin
                if (!key_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            last_word_d  = key_i;
            last_valid_d = 1'b1;
            rep_cnt_d    = match ? rep_inc : RW'(1);
            if (fail_hit) begin
                rct_fail_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);

        // Flush wins over any same-cycle push/pop; the FSM keeps its own state.
        if (clear_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            rct_fail_d   = 1'b0;
            last_valid_d = 1'b0;
            rep_cnt_d    = '0;
        end

        intr_d = rct_fail_d || ((threshold_i != '0) && (level_d >= threshold_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rct_fail_q   <= 1'b0;
            intr_q       <= 1'b0;
            last_word_q  <= '0;
            last_valid_q <= 1'b0;
            rep_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rct_fail_q   <= rct_fail_d;
            intr_q       <= intr_d;
            last_word_q  <= last_word_d;
            last_valid_q <= last_valid_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_i;
        end
    end

    assign ack_read_o = ack_q;
    assign level_o    = level_q;
    assign rct_fail_o = rct_fail_q;
    assign intr_o     = intr_q;
    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];

endmodule
